// File: rtl/prbs_randomizer_par.sv
// WiMax PHY data randomizer: DATA_W bits per beat through a 15-stage LFSR,
// valid/ready handshake, registered output, bypass and per-block reseed.
module prbs_randomizer_par #(
  parameter int unsigned           DATA_W     = 8,
  parameter int unsigned           LFSR_LEN   = 15,
  parameter logic [LFSR_LEN-1:0]   TAPS       = 15'h6000,
  parameter int unsigned           BLOCK_BITS = 96
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed,
  input  logic                en,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int unsigned       CNT_W    = $clog2(BLOCK_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_BITS - DATA_W);
  localparam logic [CNT_W-1:0]  STEP     = CNT_W'(DATA_W);

  logic [LFSR_LEN-1:0] r;
  logic [LFSR_LEN-1:0] seed_q;
  logic [CNT_W-1:0]    blk_cnt;
  logic [LFSR_LEN-1:0] r_next;
  logic [DATA_W-1:0]   scr;
  logic                fb;
  logic                accept;
  logic                last_beat;

  assign s_ready   = !load && (!m_valid || m_ready);
  assign accept    = s_valid && s_ready;
  assign last_beat = (blk_cnt == LAST_CNT);

  // Serial LFSR unrolled DATA_W times; step k consumes s_data[DATA_W-1-k] (MSB first).
  always_comb begin
    r_next = r;
    scr    = '0;
    fb     = 1'b0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      fb                  = ^(r_next & TAPS);
      scr[DATA_W-1-k]     = s_data[DATA_W-1-k] ^ fb;
      r_next              = {r_next[LFSR_LEN-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r       <= '0;
      seed_q  <= '0;
      blk_cnt <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      // load blocks acceptance through s_ready, so it never collides with a reseed
      if (load) begin
        r       <= seed;
        seed_q  <= seed;
        blk_cnt <= '0;
      end
      if (accept) begin
        m_data  <= en ? scr : s_data;
        m_valid <= 1'b1;
        m_last  <= last_beat;
        if (last_beat) begin
          r       <= seed_q;
          blk_cnt <= '0;
        end else begin
          if (en) begin
            r <= r_next;
          end
          blk_cnt <= blk_cnt + STEP;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
